// File: rtl/ysyx_220053_mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU (read/write).
// One transaction in flight; LSU wins ties unless the IFU has been starved.
module ysyx_220053_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_req_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic [1:0]          owner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IFU  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  logic [1:0]          state;
  logic [1:0]          owner_q;
  logic [3:0]          streak;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;

  logic idle;
  logic ifu_starved;
  logic grant_ls;
  logic grant_if;
  logic resp_fire;

  // NOTE: outputs built from live inputs are also gated by rst, so every
  // output reads 0 during reset even while requesters keep driving valid.
  always_comb begin
    idle        = rst && (state == S_IDLE);
    ifu_starved = if_req_valid && (streak == STREAK_MAX);
    grant_ls    = idle && ls_req_valid && !ifu_starved;
    grant_if    = idle && if_req_valid && !grant_ls;
    resp_fire   = rst && (state == S_RESP) && mem_resp_valid;
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;

  assign if_resp_valid = resp_fire && (owner_q == OWN_IFU);
  assign ls_resp_valid = resp_fire && (owner_q == OWN_LSU);
  assign if_resp_data  = if_resp_valid ? mem_resp_data : '0;
  assign ls_resp_data  = ls_resp_valid ? mem_resp_data : '0;

  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign owner         = owner_q;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      owner_q <= OWN_NONE;
      streak  <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_ls) begin
            addr_q  <= ls_req_addr;
            wen_q   <= ls_req_wen;
            wdata_q <= ls_req_wdata;
            wmask_q <= ls_req_wmask;
            owner_q <= OWN_LSU;
            state   <= S_REQ;
            // Streak only grows while the IFU is actually waiting.
            if (!if_req_valid)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end else if (grant_if) begin
            addr_q  <= if_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            owner_q <= OWN_IFU;
            state   <= S_REQ;
            streak  <= '0;
          end
        end
        S_REQ: begin
          if (mem_req_ready)
            state <= S_RESP;
        end
        S_RESP: begin
          if (mem_resp_valid) begin
            state   <= S_IDLE;
            owner_q <= OWN_NONE;
          end
        end
        default: begin
          state   <= S_IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Directed self-checking bench for ysyx_220053_mem_arbiter: IFU-only, LSU
// priority, starvation release, slow memory, stray responses, mid-flight reset.
module tb_ysyx_220053_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [63:0] if_resp_data;
  logic        ls_req_valid;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_req_ready;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_data;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic [1:0]  owner;

  int tests_run = 0;
  int tests_failed = 0;

  ysyx_220053_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_req_ready"},  64'(if_req_ready),  64'd0);
    check({tag, ".ls_req_ready"},  64'(ls_req_ready),  64'd0);
    check({tag, ".if_resp_valid"}, 64'(if_resp_valid), 64'd0);
    check({tag, ".if_resp_data"},  if_resp_data,       64'd0);
    check({tag, ".ls_resp_valid"}, 64'(ls_resp_valid), 64'd0);
    check({tag, ".ls_resp_data"},  ls_resp_data,       64'd0);
    check({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, ".mem_req_addr"},  mem_req_addr,       64'd0);
    check({tag, ".mem_req_wen"},   64'(mem_req_wen),   64'd0);
    check({tag, ".mem_req_wdata"}, mem_req_wdata,      64'd0);
    check({tag, ".mem_req_wmask"}, 64'(mem_req_wmask), 64'd0);
    check({tag, ".owner"},         64'(owner),         64'd0);
  endtask

  initial begin
    int ls_pulses;
    logic exp_ifu;

    rst = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_1000; ls_req_wen = 1'b1;
    ls_req_wdata = 64'hFFFF; ls_req_wmask = 8'hFF;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h1234;

    // Reset: all outputs zero even with requests driven.
    #3;
    check_all_zero("reset");
    if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_wen = 1'b0;
    ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // IFU only, zero-wait memory.
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h0000_0413;
    @(negedge clk);
    check("t1.c0.if_req_ready", 64'(if_req_ready), 64'd1);
    check("t1.c0.mem_req_valid", 64'(mem_req_valid), 64'd0);
    next_cycle();
    if_req_valid = 1'b0;
    @(negedge clk);
    check("t1.c1.mem_req_valid", 64'(mem_req_valid), 64'd1);
    check("t1.c1.mem_req_addr", mem_req_addr, 64'h8000_0000);
    check("t1.c1.mem_req_wen", 64'(mem_req_wen), 64'd0);
    check("t1.c1.owner", 64'(owner), 64'd1);
    check("t1.c1.if_resp_valid", 64'(if_resp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t1.c2.if_resp_valid", 64'(if_resp_valid), 64'd1);
    check("t1.c2.if_resp_data", if_resp_data, 64'h0000_0413);
    check("t1.c2.ls_resp_valid", 64'(ls_resp_valid), 64'd0);
    check("t1.c2.ls_resp_data", ls_resp_data, 64'd0);
    check("t1.c2.mem_req_valid", 64'(mem_req_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t1.c3.owner", 64'(owner), 64'd0);
    check("t1.c3.if_resp_valid", 64'(if_resp_valid), 64'd0);

    // Simultaneous requests: LSU write first, then IFU.
    next_cycle();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_1000; ls_req_wen = 1'b1;
    ls_req_wdata = 64'hDEAD_BEEF; ls_req_wmask = 8'h0F;
    @(negedge clk);
    check("t2.c0.ls_req_ready", 64'(ls_req_ready), 64'd1);
    check("t2.c0.if_req_ready", 64'(if_req_ready), 64'd0);
    next_cycle();
    ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
    @(negedge clk);
    check("t2.c1.mem_req_addr", mem_req_addr, 64'h8000_1000);
    check("t2.c1.mem_req_wen", 64'(mem_req_wen), 64'd1);
    check("t2.c1.mem_req_wdata", mem_req_wdata, 64'hDEAD_BEEF);
    check("t2.c1.mem_req_wmask", 64'(mem_req_wmask), 64'h0F);
    check("t2.c1.owner", 64'(owner), 64'd2);
    check("t2.c1.if_req_ready", 64'(if_req_ready), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t2.c2.ls_resp_valid", 64'(ls_resp_valid), 64'd1);
    check("t2.c2.if_resp_valid", 64'(if_resp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t2.c3.if_req_ready", 64'(if_req_ready), 64'd1);
    next_cycle();
    if_req_valid = 1'b0;
    @(negedge clk);
    check("t2.c4.mem_req_addr", mem_req_addr, 64'h8000_0004);
    check("t2.c4.mem_req_wen", 64'(mem_req_wen), 64'd0);
    check("t2.c4.mem_req_wdata", mem_req_wdata, 64'd0);
    check("t2.c4.mem_req_wmask", 64'(mem_req_wmask), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t2.c5.if_resp_valid", 64'(if_resp_valid), 64'd1);
    next_cycle();

    // Starvation: both held valid; expect L L L L I L L L L I.
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_2000; ls_req_wen = 1'b0;
    mem_resp_data = 64'h0000_00AA;
    for (int g = 0; g < 10; g++) begin
      exp_ifu = (g == 4) || (g == 9);
      @(negedge clk);
      check($sformatf("t3.g%0d.if_req_ready", g), 64'(if_req_ready), 64'(exp_ifu));
      check($sformatf("t3.g%0d.ls_req_ready", g), 64'(ls_req_ready), 64'(!exp_ifu));
      next_cycle();
      if (g == 9) begin
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("t3.g%0d.owner", g), 64'(owner), exp_ifu ? 64'd1 : 64'd2);
      next_cycle();
      @(negedge clk);
      check($sformatf("t3.g%0d.if_resp_valid", g), 64'(if_resp_valid), 64'(exp_ifu));
      check($sformatf("t3.g%0d.ls_resp_valid", g), 64'(ls_resp_valid), 64'(!exp_ifu));
      next_cycle();
    end

    // Slow memory: ready low 3 cycles, response 5 cycles after acceptance.
    if_req_valid = 1'b1; if_req_addr = 64'h8000_000C;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_3000; ls_req_wen = 1'b1;
    ls_req_wdata = 64'hCAFE_F00D_1234_5678; ls_req_wmask = 8'hF0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'h55;
    ls_pulses = 0;
    @(negedge clk);
    check("t4.grant.ls_req_ready", 64'(ls_req_ready), 64'd1);
    check("t4.grant.if_req_ready", 64'(if_req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 0) begin
        ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0;
        ls_req_wdata = '0; ls_req_wmask = '0;
      end
      mem_req_ready = (i == 3);
      @(negedge clk);
      check($sformatf("t4.req%0d.mem_req_valid", i), 64'(mem_req_valid), 64'd1);
      check($sformatf("t4.req%0d.mem_req_addr", i), mem_req_addr, 64'h8000_3000);
      check($sformatf("t4.req%0d.mem_req_wen", i), 64'(mem_req_wen), 64'd1);
      check($sformatf("t4.req%0d.mem_req_wdata", i), mem_req_wdata, 64'hCAFE_F00D_1234_5678);
      check($sformatf("t4.req%0d.mem_req_wmask", i), 64'(mem_req_wmask), 64'hF0);
      check($sformatf("t4.req%0d.if_req_ready", i), 64'(if_req_ready), 64'd0);
      ls_pulses += int'(ls_resp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      mem_req_ready = 1'b0;
      mem_resp_valid = (i == 4);
      mem_resp_data = (i == 4) ? 64'h1122_3344_5566_7788 : 64'h55;
      @(negedge clk);
      check($sformatf("t4.resp%0d.mem_req_valid", i), 64'(mem_req_valid), 64'd0);
      check($sformatf("t4.resp%0d.if_req_ready", i), 64'(if_req_ready), 64'd0);
      check($sformatf("t4.resp%0d.ls_resp_data", i), ls_resp_data,
            (i == 4) ? 64'h1122_3344_5566_7788 : 64'd0);
      check($sformatf("t4.resp%0d.if_resp_valid", i), 64'(if_resp_valid), 64'd0);
      ls_pulses += int'(ls_resp_valid);
    end
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    ls_pulses += int'(ls_resp_valid);
    check("t4.ls_resp_pulses", 64'(ls_pulses), 64'd1);
    check("t4.idle.if_req_ready", 64'(if_req_ready), 64'd1);
    next_cycle();
    if_req_valid = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    mem_resp_data = 64'h0000_0513;
    @(negedge clk);
    check("t4.ifu.mem_req_addr", mem_req_addr, 64'h8000_000C);
    next_cycle();
    @(negedge clk);
    check("t4.ifu.if_resp_data", if_resp_data, 64'h0000_0513);
    next_cycle();

    // Stray responses in IDLE are ignored.
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("t5.%0d.if_resp_valid", i), 64'(if_resp_valid), 64'd0);
      check($sformatf("t5.%0d.ls_resp_valid", i), 64'(ls_resp_valid), 64'd0);
      check($sformatf("t5.%0d.if_resp_data", i), if_resp_data, 64'd0);
      check($sformatf("t5.%0d.owner", i), 64'(owner), 64'd0);
      check($sformatf("t5.%0d.mem_req_valid", i), 64'(mem_req_valid), 64'd0);
      next_cycle();
    end
    mem_resp_valid = 1'b0;

    // Reset while in RESP, then a fresh IFU transaction.
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0010; mem_req_ready = 1'b1;
    @(negedge clk);
    check("t6.grant.if_req_ready", 64'(if_req_ready), 64'd1);
    next_cycle();
    if_req_valid = 1'b0;
    next_cycle();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("t6.resp.owner", 64'(owner), 64'd1);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    #1;
    check("t6.pre.if_resp_valid", 64'(if_resp_valid), 64'd1);
    rst = 1'b0;
    #1;
    check_all_zero("t6.rst");
    next_cycle();
    if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_resp_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h0010_0093;
    @(negedge clk);
    check("t6.new.if_req_ready", 64'(if_req_ready), 64'd1);
    next_cycle();
    if_req_valid = 1'b0;
    @(negedge clk);
    check("t6.new.mem_req_addr", mem_req_addr, 64'h8000_0008);
    next_cycle();
    @(negedge clk);
    check("t6.new.if_resp_valid", 64'(if_resp_valid), 64'd1);
    check("t6.new.if_resp_data", if_resp_data, 64'h0010_0093);
    next_cycle();
    @(negedge clk);
    check("t6.new.owner", 64'(owner), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
